// File: rtl/regfile_alu_sequencer.sv
//==== regfile_alu_sequencer: valid/ready command sequencer, sole driver of RegFile_Alu controls
//==== rev 1.0
`default_nettype none

module regfile_alu_sequencer #(
  parameter bit         CLEAR_ON_RESET = 1'b1,
  parameter logic [4:0] MOVI_OP        = 5'b01101
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [4:0]  cmd_opcode,
  input  logic        cmd_imm_s,
  input  logic [3:0]  cmd_rdest,
  input  logic [3:0]  cmd_rsrc,
  input  logic [15:0] cmd_imm,
  input  logic        cmd_wb,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [15:0] resp_data,
  output logic [4:0]  resp_flags,
  output logic        busy,
  output logic [3:0]  alu_rdest,
  output logic [3:0]  alu_rsrc,
  output logic        alu_en,
  output logic        alu_rst,
  output logic [15:0] alu_imm,
  output logic        alu_imm_s,
  output logic [4:0]  alu_opcode,
  input  logic [15:0] alu_result,
  input  logic [4:0]  alu_flags
);

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_IDLE = 2'd1,
    S_EXEC = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t      state_q;
  logic [3:0]  clr_cnt_q;
  logic        cmd_ready_q;
  logic        resp_valid_q;
  logic [15:0] resp_data_q;
  logic [4:0]  resp_flags_q;
  logic        alu_en_q;
  logic [3:0]  alu_rdest_q;
  logic [3:0]  alu_rsrc_q;
  logic [15:0] alu_imm_q;
  logic        alu_imm_s_q;
  logic [4:0]  alu_opcode_q;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      if (CLEAR_ON_RESET) state_q <= S_INIT;
      else                state_q <= S_IDLE;
      clr_cnt_q    <= 4'd0;
      cmd_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= 16'h0000;
      resp_flags_q <= 5'd0;
      alu_en_q     <= 1'b0;
      alu_rdest_q  <= 4'd0;
      alu_rsrc_q   <= 4'd0;
      alu_imm_q    <= 16'h0000;
      alu_imm_s_q  <= 1'b0;
      alu_opcode_q <= 5'd0;
    end else begin
      case (state_q)
        // Clear R0..R15 with MOVI #0, one register per cycle.
        S_INIT: begin
          alu_en_q     <= 1'b1;
          alu_opcode_q <= MOVI_OP;
          alu_imm_s_q  <= 1'b1;
          alu_imm_q    <= 16'h0000;
          alu_rdest_q  <= clr_cnt_q;
          clr_cnt_q    <= clr_cnt_q + 4'd1;
          if (clr_cnt_q == 4'hF) state_q <= S_IDLE;
        end
        S_IDLE: begin
          alu_en_q <= 1'b0;
          if (cmd_valid && cmd_ready_q) begin
            alu_opcode_q <= cmd_opcode;
            alu_imm_s_q  <= cmd_imm_s;
            alu_rdest_q  <= cmd_rdest;
            alu_rsrc_q   <= cmd_rsrc;
            alu_imm_q    <= cmd_imm;
            alu_en_q     <= cmd_wb;
            cmd_ready_q  <= 1'b0;
            state_q      <= S_EXEC;
          end else begin
            cmd_ready_q <= 1'b1;
          end
        end
        // Capture happens on the same edge as the register write, so the
        // response carries the pre-write ALU output.
        S_EXEC: begin
          alu_en_q     <= 1'b0;
          resp_data_q  <= alu_result;
          resp_flags_q <= alu_flags;
          resp_valid_q <= 1'b1;
          state_q      <= S_RESP;
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            cmd_ready_q  <= 1'b1;
            state_q      <= S_IDLE;
          end
        end
        default: begin
          alu_en_q    <= 1'b0;
          cmd_ready_q <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_flags = resp_flags_q;
  assign busy       = (state_q != S_IDLE);
  assign alu_rdest  = alu_rdest_q;
  assign alu_rsrc   = alu_rsrc_q;
  assign alu_en     = alu_en_q;
  assign alu_rst    = Rst;
  assign alu_imm    = alu_imm_q;
  assign alu_imm_s  = alu_imm_s_q;
  assign alu_opcode = alu_opcode_q;

endmodule

`default_nettype wire

// File: tb/tb_regfile_alu_sequencer.sv
//==== tb_regfile_alu_sequencer: bench for regfile_alu_sequencer with a stub RegFile_Alu
//==== rev 1.0
`default_nettype none

module tb_regfile_alu_sequencer;

  localparam logic [4:0] OP_AND  = 5'b00001;
  localparam logic [4:0] OP_OR   = 5'b00010;
  localparam logic [4:0] OP_XOR  = 5'b00011;
  localparam logic [4:0] OP_ADD  = 5'b00101;
  localparam logic [4:0] OP_SUB  = 5'b01001;
  localparam logic [4:0] OP_CMP  = 5'b01011;
  localparam logic [4:0] OP_MOVI = 5'b01101;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready;
  logic [4:0]  cmd_opcode = '0;
  logic        cmd_imm_s = 1'b0;
  logic [3:0]  cmd_rdest = '0, cmd_rsrc = '0;
  logic [15:0] cmd_imm = '0;
  logic        cmd_wb = 1'b0;
  logic        resp_valid, resp_ready = 1'b0;
  logic [15:0] resp_data;
  logic [4:0]  resp_flags;
  logic        busy;
  logic [3:0]  alu_rdest, alu_rsrc;
  logic        alu_en, alu_rst;
  logic [15:0] alu_imm;
  logic        alu_imm_s;
  logic [4:0]  alu_opcode;
  logic [15:0] alu_result;
  logic [4:0]  alu_flags;

  int tests = 0;
  int fails = 0;

  regfile_alu_sequencer #(.CLEAR_ON_RESET(1'b1), .MOVI_OP(OP_MOVI)) dut (
    .Clk(Clk), .Rst(Rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
    .cmd_imm_s(cmd_imm_s), .cmd_rdest(cmd_rdest), .cmd_rsrc(cmd_rsrc),
    .cmd_imm(cmd_imm), .cmd_wb(cmd_wb),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_flags(resp_flags), .busy(busy),
    .alu_rdest(alu_rdest), .alu_rsrc(alu_rsrc), .alu_en(alu_en), .alu_rst(alu_rst),
    .alu_imm(alu_imm), .alu_imm_s(alu_imm_s), .alu_opcode(alu_opcode),
    .alu_result(alu_result), .alu_flags(alu_flags)
  );

  always #5 Clk = ~Clk;

  // ALU semantics shared by the stub datapath and the scoreboard: {flags, result},
  // flags = {2'b00, carry/borrow, negative, zero}.
  function automatic logic [20:0] alu_ref(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [16:0] w;
    logic        c;
    w = 17'd0;
    c = 1'b0;
    case (op)
      OP_ADD:         begin w = {1'b0, a} + {1'b0, b}; c = w[16]; end
      OP_SUB, OP_CMP: begin w = {1'b0, a - b}; c = (a < b); end
      OP_MOVI:        w = {1'b0, b};
      OP_AND:         w = {1'b0, a & b};
      OP_OR:          w = {1'b0, a | b};
      OP_XOR:         w = {1'b0, a ^ b};
      default:        w = {1'b0, a};
    endcase
    return {2'b00, c, w[15], (w[15:0] == 16'h0000), w[15:0]};
  endfunction

  // Stub RegFile_Alu: registers start as junk so the clear sequence matters.
  logic [15:0] sregs [16];
  logic        seeded = 1'b0;
  logic [20:0] stub_out;

  always_comb begin
    stub_out = alu_ref(alu_opcode, sregs[alu_rdest], alu_imm_s ? alu_imm : sregs[alu_rsrc]);
    alu_result = stub_out[15:0];
    alu_flags  = stub_out[20:16];
  end

  always @(posedge Clk) begin
    if (!seeded) begin
      for (int i = 0; i < 16; i++) sregs[i] <= 16'hA5A0 ^ 16'(i);
    end else if (alu_en && alu_opcode != OP_CMP) begin
      sregs[alu_rdest] <= stub_out[15:0];
    end
  end

  // Scoreboard register file
  logic [15:0] mregs [16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called #1 after a posedge; returns #1 after the reset edge.
  task automatic do_reset();
    Rst = 1'b1;
    #1;
    chk("alu_rst_follows", 64'(alu_rst), 64'd1);
    @(posedge Clk); #1;
    Rst = 1'b0;
    chk("reset_state", 64'({cmd_ready, resp_valid, resp_data, resp_flags, alu_en,
                            alu_rdest, alu_rsrc, alu_opcode, alu_imm_s, alu_imm, busy}),
        64'({1'b0, 1'b0, 16'h0, 5'd0, 1'b0, 4'd0, 4'd0, 5'd0, 1'b0, 16'h0, 1'b1}));
    for (int r = 0; r < 16; r++) mregs[r] = 16'h0000;
  endtask

  // Reset then watch the 16-step clear; optional second reset after step abort_at.
  task automatic check_clear(input int abort_at);
    int i;
    int ab;
    ab = abort_at;
    do_reset();
    i = 0;
    while (i < 16) begin
      @(posedge Clk); #1;
      chk("init_step", 64'({alu_en, alu_rdest, alu_opcode, alu_imm_s, alu_imm, cmd_ready, busy}),
          64'({1'b1, 4'(i), OP_MOVI, 1'b1, 16'h0, 1'b0, (i < 15)}));
      if (i == ab) begin
        do_reset();
        ab = -1;
        i = 0;
      end else begin
        i++;
      end
    end
    @(posedge Clk); #1;
    chk("init_done", 64'({alu_en, cmd_ready, busy}), 64'({1'b0, 1'b1, 1'b0}));
  endtask

  // One command with full protocol checks; resp_ready held low for 'hold' cycles.
  task automatic send(input logic [4:0] op, input logic ims, input logic [3:0] rd, input logic [3:0] rs,
                      input logic [15:0] imm, input logic wb, input int hold,
                      output logic [15:0] d, output logic [4:0] f);
    int n;
    n = 0;
    cmd_opcode = op; cmd_imm_s = ims; cmd_rdest = rd; cmd_rsrc = rs; cmd_imm = imm; cmd_wb = wb;
    cmd_valid = 1'b1;
    resp_ready = 1'b0;
    while (!cmd_ready && n < 20) begin @(posedge Clk); #1; n++; end
    if (n >= 20) chk("accept_timeout", 64'd1, 64'd0);
    @(posedge Clk); #1;
    cmd_valid = 1'b0;
    chk("exec_en", 64'(alu_en), 64'(wb));
    chk("exec_fields", 64'({alu_opcode, alu_imm_s, alu_rdest, alu_rsrc, alu_imm, resp_valid, cmd_ready}),
        64'({op, ims, rd, rs, imm, 1'b0, 1'b0}));
    @(posedge Clk); #1;
    chk("resp_up", 64'({resp_valid, alu_en, busy}), 64'({1'b1, 1'b0, 1'b1}));
    d = resp_data;
    f = resp_flags;
    if (hold > 0) begin
      cmd_valid = 1'b1;
      cmd_opcode = OP_XOR;
      for (int k = 0; k < hold; k++) begin
        @(posedge Clk); #1;
        chk("stall_stable", 64'({resp_valid, resp_data, resp_flags, cmd_ready, alu_opcode, alu_en}),
            64'({1'b1, d, f, 1'b0, op, 1'b0}));
      end
      cmd_valid = 1'b0;
    end
    resp_ready = 1'b1;
    @(posedge Clk); #1;
    resp_ready = 1'b0;
    chk("resp_done", 64'({resp_valid, cmd_ready, busy, alu_opcode}), 64'({1'b0, 1'b1, 1'b0, op}));
  endtask

  task automatic rand_cmd();
    case ($urandom_range(0, 6))
      0: cmd_opcode = OP_ADD;
      1: cmd_opcode = OP_SUB;
      2: cmd_opcode = OP_CMP;
      3: cmd_opcode = OP_MOVI;
      4: cmd_opcode = OP_AND;
      5: cmd_opcode = OP_OR;
      default: cmd_opcode = OP_XOR;
    endcase
    cmd_imm_s = 1'($urandom_range(0, 1));
    cmd_rdest = 4'($urandom_range(0, 15));
    cmd_rsrc  = 4'($urandom_range(0, 15));
    cmd_imm   = 16'($urandom);
    cmd_wb    = ($urandom_range(0, 3) != 0);
  endtask

  // Random command stream against the scoreboard; btb holds resp_ready high
  // and checks the accept spacing.
  task automatic stream(input int ncmd, input bit btb);
    logic [20:0] exp_q[$];
    logic [20:0] e;
    logic [15:0] a, b;
    int accepted, got, cyc, last_acc, en_cnt, wb_cnt;
    bit acc, fire;
    accepted = 0; got = 0; cyc = 0; last_acc = -1; en_cnt = 0; wb_cnt = 0;
    rand_cmd();
    cmd_valid = 1'b1;
    resp_ready = btb ? 1'b1 : 1'($urandom_range(0, 1));
    while (got < ncmd && cyc < ncmd * 40) begin
      @(negedge Clk);
      acc  = cmd_valid && cmd_ready;
      fire = resp_valid && resp_ready;
      if (alu_en) en_cnt++;
      if (fire) begin
        if (exp_q.size() == 0) begin
          chk("spurious_resp", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("stream_data", 64'(resp_data), 64'(e[15:0]));
          chk("stream_flags", 64'(resp_flags), 64'(e[20:16]));
        end
        got++;
      end
      if (acc) begin
        a = mregs[cmd_rdest];
        b = cmd_imm_s ? cmd_imm : mregs[cmd_rsrc];
        e = alu_ref(cmd_opcode, a, b);
        exp_q.push_back(e);
        if (cmd_wb && cmd_opcode != OP_CMP) mregs[cmd_rdest] = e[15:0];
        if (cmd_wb) wb_cnt++;
        if (btb && last_acc >= 0) chk("btb_spacing", 64'(cyc - last_acc), 64'd3);
        last_acc = cyc;
        accepted++;
      end
      cyc++;
      @(posedge Clk); #1;
      if (acc) begin
        if (accepted < ncmd) rand_cmd();
        else cmd_valid = 1'b0;
      end
      if (!btb) resp_ready = 1'($urandom_range(0, 1));
    end
    cmd_valid = 1'b0;
    resp_ready = 1'b0;
    chk("stream_all_responses", 64'(got), 64'(ncmd));
    chk("stream_en_pulses", 64'(en_cnt), 64'(wb_cnt));
  endtask

  typedef struct {
    logic [4:0]  op;
    logic        ims;
    logic [3:0]  rd;
    logic [3:0]  rs;
    logic [15:0] imm;
    logic        wb;
    int          hold;
    logic [15:0] ed;
    logic [4:0]  ef;
  } vec_t;

  vec_t vt [10];

  initial begin
    logic [15:0] d;
    logic [4:0]  f;
    vt[0] = '{OP_ADD,  1'b1, 4'd3,  4'd0,  16'h0040, 1'b1, 0,  16'h0040, 5'b00000};
    vt[1] = '{OP_ADD,  1'b0, 4'd3,  4'd3,  16'h0000, 1'b1, 0,  16'h0080, 5'b00000};
    vt[2] = '{OP_CMP,  1'b0, 4'd3,  4'd3,  16'h0000, 1'b0, 0,  16'h0000, 5'b00001};
    vt[3] = '{OP_ADD,  1'b0, 4'd3,  4'd3,  16'h0000, 1'b1, 10, 16'h0100, 5'b00000};
    vt[4] = '{OP_MOVI, 1'b1, 4'd5,  4'd0,  16'h1234, 1'b1, 0,  16'h1234, 5'b00000};
    vt[5] = '{OP_SUB,  1'b0, 4'd5,  4'd3,  16'h0000, 1'b1, 0,  16'h1134, 5'b00000};
    vt[6] = '{OP_XOR,  1'b1, 4'd5,  4'd0,  16'h1134, 1'b0, 3,  16'h0000, 5'b00001};
    vt[7] = '{OP_ADD,  1'b1, 4'd15, 4'd0,  16'hFFFF, 1'b1, 0,  16'hFFFF, 5'b00010};
    vt[8] = '{OP_ADD,  1'b1, 4'd15, 4'd0,  16'h0001, 1'b1, 0,  16'h0000, 5'b00101};
    vt[9] = '{OP_AND,  1'b0, 4'd15, 4'd15, 16'h0000, 1'b1, 0,  16'h0000, 5'b00001};

    @(posedge Clk); #1;
    seeded = 1'b1;

    check_clear(-1);

    for (int v = 0; v < 10; v++) begin
      send(vt[v].op, vt[v].ims, vt[v].rd, vt[v].rs, vt[v].imm, vt[v].wb, vt[v].hold, d, f);
      chk($sformatf("vec%0d_data", v), 64'(d), 64'(vt[v].ed));
      chk($sformatf("vec%0d_flags", v), 64'(f), 64'(vt[v].ef));
    end

    // Reset in the middle of the clear sequence restarts it from R0.
    check_clear(6);

    // Reset while a response is pending drops it.
    cmd_opcode = OP_MOVI; cmd_imm_s = 1'b1; cmd_rdest = 4'd9; cmd_imm = 16'hBEEF; cmd_wb = 1'b1;
    cmd_valid = 1'b1;
    @(posedge Clk); #1;
    cmd_valid = 1'b0;
    @(posedge Clk); #1;
    chk("pending_resp", 64'({resp_valid, resp_data}), 64'({1'b1, 16'hBEEF}));
    check_clear(-1);

    stream(40, 1'b0);
    stream(12, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
    $fatal(1);
  end

endmodule

`default_nettype wire
